// File: rtl/adder_arbiter_if.sv
// Handshake bundle for adder_arbiter: two operand requesters and one result
// consumer. The slave modport is the arbiter's view, master is the
// requesters/consumer side. res_ovf exists only when ADDER_ARBITER_OVF_EN
// is defined.
interface adder_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             res_ready;
`ifdef ADDER_ARBITER_OVF_EN
  logic             res_ovf;
`endif

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
`ifdef ADDER_ARBITER_OVF_EN
    output res_ovf,
`endif
    output res_valid, res_data, res_id
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
`ifdef ADDER_ARBITER_OVF_EN
    input  res_ovf,
`endif
    input  res_valid, res_data, res_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: two requesters share one registered adder through a
// round-robin arbiter. Each operation walks IDLE -> EXEC -> RESP, so at most
// one operation is in flight and a new grant only happens back in IDLE.
// Optional feature: define ADDER_ARBITER_OVF_EN to add the registered signed
// overflow flag res_ovf alongside res_data.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_id_q;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] sum_d;
`ifdef ADDER_ARBITER_OVF_EN
  logic             ovf_d;
  logic             res_ovf_q;
`endif

  // Round-robin grant: a lone requester wins; on contention the one that was
  // not granted last wins. Gated by rst_n so nothing is accepted in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // The single shared adder; carry-out is dropped.
  assign sum_d = a_q + b_q;

`ifdef ADDER_ARBITER_OVF_EN
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif

  // Controller: capture on grant, add in EXEC, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
`ifdef ADDER_ARBITER_OVF_EN
      res_ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q          <= grant1 ? bus.req1_a : bus.req0_a;
            b_q          <= grant1 ? bus.req1_b : bus.req0_b;
            id_q         <= grant1;
            last_grant_q <= grant1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          res_data_q  <= sum_d;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
`ifdef ADDER_ARBITER_OVF_EN
          res_ovf_q   <= ovf_d;
`endif
          state_q     <= RESP;
        end
        RESP: begin
          // res_ready is only looked at here, so it is ignored elsewhere.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
`ifdef ADDER_ARBITER_OVF_EN
  assign bus.res_ovf   = res_ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single request, contention alternation,
// result backpressure, wrap-around and reset during EXEC.
module tb_adder_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_arbiter_if #(.WIDTH(32)) bus ();

  adder_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive0(1'b1, 32'd0, 32'd0);
    drive1(1'b0, 32'd0, 32'd0);
    bus.res_ready = 1'b1;

    // Reset state; valid during reset must not produce ready
    step();
    step();
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    drive0(1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    step();

    // Single request 4+8
    drive0(1'b1, 32'd4, 32'd8);
    #1;
    chk("t1_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    chk("t1_exec_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("t1_res_valid", 32'(bus.res_valid), 32'd1);
    chk("t1_res_data", bus.res_data, 32'd12);
    chk("t1_res_id", 32'(bus.res_id), 32'd0);
    step();
    chk("t1_res_clear", 32'(bus.res_valid), 32'd0);

    // Fresh reset so requester 0 wins the first contention
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Contention: req0 8+4, req1 16+1
    drive0(1'b1, 32'd8, 32'd4);
    drive1(1'b1, 32'd16, 32'd1);
    #1;
    chk("t2_c1_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t2_c1_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    chk("t2_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    chk("t2_r1_data", bus.res_data, 32'd12);
    chk("t2_r1_id", 32'(bus.res_id), 32'd0);
    chk("t2_resp_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    chk("t2_idle_req1_ready", 32'(bus.req1_ready), 32'd1);
    step();
    // req1 stays valid with a new pair, req0 rejoins -> contention again
    drive0(1'b1, 32'd8, 32'd4);
    step();
    chk("t2_r2_data", bus.res_data, 32'd17);
    chk("t2_r2_id", 32'(bus.res_id), 32'd1);
    step();
    chk("t2_c2_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t2_c2_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    step();
    chk("t2_r3_data", bus.res_data, 32'd12);
    chk("t2_r3_id", 32'(bus.res_id), 32'd0);
    step();
    chk("t2_c3_req1_ready", 32'(bus.req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'd0, 32'd0);
    step();
    chk("t2_r4_data", bus.res_data, 32'd17);
    chk("t2_r4_id", 32'(bus.res_id), 32'd1);
    step();
    chk("t2_r4_clear", 32'(bus.res_valid), 32'd0);

    // Backpressure: req1 100+23 with res_ready low for 3 cycles
    bus.res_ready = 1'b0;
    drive1(1'b1, 32'd100, 32'd23);
    #1;
    chk("t3_req1_ready", 32'(bus.req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'd0, 32'd0);
    drive0(1'b1, 32'd5, 32'd5);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_hold%0d_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("t3_hold%0d_data", i), bus.res_data, 32'd123);
      chk($sformatf("t3_hold%0d_id", i), 32'(bus.res_id), 32'd1);
      chk($sformatf("t3_hold%0d_req0_ready", i), 32'(bus.req0_ready), 32'd0);
      if (i < 2) step();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("t3_consume_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("t3_consume_valid", 32'(bus.res_valid), 32'd1);
    step();
    chk("t3_cleared", 32'(bus.res_valid), 32'd0);
    chk("t3_idle_req0_ready", 32'(bus.req0_ready), 32'd1);
    drive0(1'b0, 32'd0, 32'd0);
    step();

    // Wrap-around 0xFFFFFFFF + 1
    drive0(1'b1, 32'hFFFF_FFFF, 32'h1);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    step();
    chk("t4_wrap_data", bus.res_data, 32'h0);
`ifdef ADDER_ARBITER_OVF_EN
    chk("t4_wrap_ovf", 32'(bus.res_ovf), 32'd0);
`endif
    step();
    // Signed overflow 0x7FFFFFFF + 1
    drive0(1'b1, 32'h7FFF_FFFF, 32'h1);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    step();
    chk("t4_ovf_data", bus.res_data, 32'h8000_0000);
`ifdef ADDER_ARBITER_OVF_EN
    chk("t4_ovf_flag", 32'(bus.res_ovf), 32'd1);
`endif
    step();

    // Reset during EXEC of req1 2+3
    drive1(1'b1, 32'd2, 32'd3);
    #1;
    chk("t5_req1_ready", 32'(bus.req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'd0, 32'd0);
    rst_n = 1'b0;
    drive0(1'b1, 32'd8, 32'd4);
    drive1(1'b1, 32'd16, 32'd1);
    #1;
    chk("t5_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("t5_rst_data", bus.res_data, 32'd0);
    chk("t5_rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("t5_rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    chk("t5_rst2_valid", 32'(bus.res_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t5_post_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("t5_post_req1_ready", 32'(bus.req1_ready), 32'd0);
    step();
    drive0(1'b0, 32'd0, 32'd0);
    drive1(1'b0, 32'd0, 32'd0);
    chk("t5_post_exec_valid", 32'(bus.res_valid), 32'd0);
    step();
    chk("t5_post_data", bus.res_data, 32'd12);
    chk("t5_post_id", 32'(bus.res_id), 32'd0);
    step();
    chk("t5_post_clear", 32'(bus.res_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have req0_valid input 1, requester 0 (PC increment) has an operand pair pending.
REQ-004 SHALL have req0_a and req0_b, each input WIDTH, requester 0 operands.
REQ-005 SHALL have req0_ready output 1, requester 0 operands accepted this cycle.
REQ-006 SHALL have req1_valid input 1, requester 1 (branch target) has an operand pair pending.
REQ-007 SHALL have req1_a and req1_b, each input WIDTH, requester 1 operands.
REQ-008 SHALL have req1_ready output 1, requester 1 operands accepted this cycle.
REQ-009 SHALL have res_valid output 1, result held on res_data.
REQ-010 SHALL have res_data output WIDTH, the registered sum.
REQ-011 SHALL have res_id output 1, the index of the requester that owns res_data.
REQ-012 SHALL have res_ready input 1, consumer accepts the result.

Function
REQ-013 SHALL contain a single shared adder: res = a + b modulo 2^WIDTH, with carry-out discarded.
REQ-014 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-015 In IDLE, SHALL assert at most one reqN_ready, combinationally, only when reqN_valid is high; reqN_ready SHALL be 0 in EXEC and RESP.
REQ-016 Arbitration SHALL be round-robin: with a single valid request, that requester is granted; with both valid, the requester other than last_grant is granted.
REQ-017 A handshake (valid & ready) at edge T SHALL capture a, b and id into internal registers, update last_grant, and move IDLE->EXEC.
REQ-018 In EXEC, at edge T+1, SHALL register the sum into res_data and id into res_id, set res_valid=1, and move EXEC->RESP.
REQ-019 In RESP, res_valid, res_data and res_id SHALL stay stable until res_valid & res_ready; at that edge res_valid SHALL clear and the FSM SHALL move RESP->IDLE.
REQ-020 SHALL not accept a new request in the same cycle a result is consumed; the next grant is at the earliest one cycle after RESP exits, giving a throughput of one operation per 3 cycles minimum.
REQ-021 Requesters SHALL hold valid and operands stable until ready; deassertion of valid before ready SHALL withdraw the request without side effect.
REQ-022 res_ready asserted while res_valid=0 SHALL be ignored.

Reset
REQ-023 rst_n low SHALL, asynchronously, force state=IDLE, res_valid=0, res_data=0, res_id=0, last_grant=1 (so requester 0 wins the first contention), and clear the operand registers.
REQ-024 Reset asserted in EXEC or RESP SHALL abandon the operation; no result for it SHALL be produced after reset release.
REQ-025 req0_ready and req1_ready SHALL be 0 while rst_n is low.

Configuration
REQ-026 Macro ADDER_ARBITER_OVF_EN defined: SHALL add output res_ovf 1, the registered signed overflow of the sum (operands of equal sign, result of different sign), valid and held with res_data, and reset to 0.
REQ-027 Macro ADDER_ARBITER_OVF_EN undefined: res_ovf SHALL be absent and no overflow logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL check req0 a=4, b=8 with res_ready=1 -> req0_ready high in IDLE; res_valid one edge after the accept edge, with res_data=12 and res_id=0.
REQ-029 Bench SHALL check req0 and req1 both valid after reset (req0 8+4, req1 16+1) -> req0 served first with 12/id 0, then req1 with 17/id 1; repeated contention alternates.
REQ-030 Bench SHALL check result backpressure (res_ready low 3 cycles, then high) -> res_valid, res_data and res_id stable for all 3 cycles, clearing one edge after res_ready rises; no reqN_ready during the hold.
REQ-031 Bench SHALL check wrap-around: 0xFFFFFFFF+0x1 -> res_data=0x0 (res_ovf=0); 0x7FFFFFFF+0x1 -> 0x80000000 (res_ovf=1 when ADDER_ARBITER_OVF_EN is defined).
REQ-032 Bench SHALL check reset pulsed in EXEC during req1 2+3 -> res_valid stays 0, res_data=0, FSM returns to IDLE; after release, contention grants req0 first.
